// File: rtl/mesm6_busctl.sv
// MESM-6 bus controller: decodes CPU word addresses to data RAM or NDEV
// 8-word I/O windows, runs the request FSM with a slave timeout watchdog and
// reports bus errors. The pic_irq vector fans the slave interrupts into the PIC.
// Optional feature macro: MESM6_BUSCTL_ERRLOG_EN adds a sticky first-error log.
module mesm6_busctl #(
  parameter int unsigned AW      = 15,
  parameter int unsigned DW      = 48,
  parameter int unsigned NDEV    = 6,
  parameter logic [5:0]  RAM_TOP = 6'o77,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [AW-1:0]      cpu_addr,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic [DW-1:0]      cpu_wdata,
  output logic [DW-1:0]      cpu_rdata,
  output logic               cpu_done,
  output logic               cpu_err,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic               mem_read,
  output logic               mem_write,
  input  logic [DW-1:0]      mem_rdata,
  input  logic               mem_done,
  output logic [AW-1:0]      dev_addr,
  output logic [DW-1:0]      dev_wdata,
  output logic [NDEV-1:0]    dev_read,
  output logic [NDEV-1:0]    dev_write,
  input  logic [NDEV*DW-1:0] dev_rdata,
  input  logic [NDEV-1:0]    dev_done,
  input  logic [NDEV-1:0]    dev_int,
  output logic [DW-1:0]      pic_irq
`ifdef MESM6_BUSCTL_ERRLOG_EN
  ,
  output logic [AW-1:0]      err_addr,
  output logic               err_valid,
  input  logic               err_clr
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned WW = AW - 3;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              started_q, started_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [NDEV-1:0]   dev_read_q, dev_read_d, dev_write_q, dev_write_d;
  logic              done_q, done_d, err_q, err_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_evt;

  logic              is_io, bad, tgt_done;
  logic [WW-1:0]     win_idx;
  logic [NDEV-1:0]   dev_sel;
  logic [DW-1:0]     tgt_rdata;

  // Decode the latched address into a target and mux its done/rdata
  always_comb begin
    is_io     = (addr_q[AW-1 -: 6] == RAM_TOP);
    win_idx   = ~addr_q[AW-1:3];
    dev_sel   = '0;
    tgt_done  = 1'b0;
    tgt_rdata = '0;
    for (int i = 0; i < int'(NDEV); i++) begin
      if (is_io && (win_idx == WW'(i))) dev_sel[i] = 1'b1;
    end
    if (!is_io) begin
      tgt_done  = mem_done;
      tgt_rdata = mem_rdata;
    end
    for (int i = 0; i < int'(NDEV); i++) begin
      if (dev_sel[i]) begin
        tgt_done  = tgt_done | dev_done[i];
        tgt_rdata = tgt_rdata | dev_rdata[i*DW +: DW];
      end
    end
    bad = (rd_q && wr_q) || (is_io && (dev_sel == '0));
  end

  // Next-state and next-output logic of the request FSM
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    started_d   = started_q;
    timer_d     = timer_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    dev_read_d  = dev_read_q;
    dev_write_d = dev_write_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    err_evt     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_read || cpu_write) begin
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          rd_d      = cpu_read;
          wr_d      = cpu_write;
          started_d = 1'b0;
          timer_d   = '0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (!started_q) begin
          // First ACCESS cycle: raise the strobe unless the request is illegal
          started_d = 1'b1;
          if (!bad) begin
            mem_read_d  = rd_q && !is_io;
            mem_write_d = wr_q && !is_io;
            dev_read_d  = rd_q ? dev_sel : '0;
            dev_write_d = wr_q ? dev_sel : '0;
          end
        end else if (bad) begin
          state_d = RESP;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          err_evt = 1'b1;
        end else if (tgt_done) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          dev_read_d  = '0;
          dev_write_d = '0;
          state_d     = RESP;
          done_d      = 1'b1;
          rdata_d     = rd_q ? tgt_rdata : '0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          dev_read_d  = '0;
          dev_write_d = '0;
          state_d     = RESP;
          done_d      = 1'b1;
          err_d       = 1'b1;
          rdata_d     = '0;
          err_evt     = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!cpu_read && !cpu_write) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      started_q   <= 1'b0;
      timer_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      dev_read_q  <= '0;
      dev_write_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      started_q   <= started_d;
      timer_q     <= timer_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      dev_read_q  <= dev_read_d;
      dev_write_q <= dev_write_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef MESM6_BUSCTL_ERRLOG_EN
  // Sticky first-error log; a new error beats a concurrent clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (err_evt && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_addr  <= addr_q;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end
`else
  logic unused_err_evt;
  assign unused_err_evt = err_evt;
`endif

  // Slave interrupts to the PIC; the PIC's own request is not looped back
  always_comb begin
    pic_irq = '0;
    for (int i = 1; i < int'(NDEV); i++) pic_irq[i-1] = dev_int[i];
  end

  logic unused_pic_int;
  assign unused_pic_int = dev_int[0];

  assign cpu_rdata = rdata_q;
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;
  assign dev_read  = dev_read_q;
  assign dev_write = dev_write_q;

endmodule

// File: tb/tb_mesm6_busctl.sv
// Directed testbench for mesm6_busctl (default parameters).
// Define MESM6_BUSCTL_ERRLOG_EN to also exercise the error-log ports.
module tb_mesm6_busctl;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 48;
  localparam int unsigned NDEV = 6;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [AW-1:0]      cpu_addr;
  logic               cpu_read, cpu_write;
  logic [DW-1:0]      cpu_wdata, cpu_rdata;
  logic               cpu_done, cpu_err;
  logic [AW-1:0]      mem_addr, dev_addr;
  logic [DW-1:0]      mem_wdata, dev_wdata, mem_rdata;
  logic               mem_read, mem_write, mem_done;
  logic [NDEV-1:0]    dev_read, dev_write, dev_done, dev_int;
  logic [NDEV*DW-1:0] dev_rdata;
  logic [DW-1:0]      pic_irq;
`ifdef MESM6_BUSCTL_ERRLOG_EN
  logic [AW-1:0]      err_addr;
  logic               err_valid, err_clr;
`endif

  int checks = 0;
  int errors = 0;

  mesm6_busctl dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_read(dev_read), .dev_write(dev_write),
    .dev_rdata(dev_rdata), .dev_done(dev_done), .dev_int(dev_int), .pic_irq(pic_irq)
`ifdef MESM6_BUSCTL_ERRLOG_EN
    , .err_addr(err_addr), .err_valid(err_valid), .err_clr(err_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int ndone;
    int nstb;

    reset_n = 1'b0;
    cpu_addr = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wdata = '0;
    mem_rdata = '0; mem_done = 1'b0;
    dev_rdata = '0; dev_done = '0; dev_int = '0;
`ifdef MESM6_BUSCTL_ERRLOG_EN
    err_clr = 1'b0;
`endif
    tick(); tick();
    chk("rst_done", 64'(cpu_done), 64'd0);
    chk("rst_err", 64'(cpu_err), 64'd0);
    chk("rst_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_strobes", 64'({mem_read, mem_write, dev_read, dev_write}), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(dev_wdata), 64'd0);
`ifdef MESM6_BUSCTL_ERRLOG_EN
    chk("rst_err_valid", 64'(err_valid), 64'd0);
`endif
    reset_n = 1'b1;
    tick();

    // RAM read, 0-wait slave; CPU address changes mid-access
    cpu_addr = 15'o01234; cpu_read = 1'b1; mem_rdata = 48'h1234_5678_9ABC;
    tick();
    chk("t1_e0_strobe", 64'(mem_read), 64'd0);
    cpu_addr = 15'o00007;
    tick();
    chk("t1_e1_strobe", 64'(mem_read), 64'd1);
    chk("t1_e1_addr", 64'(mem_addr), 64'(15'o01234));
    chk("t1_e1_done", 64'(cpu_done), 64'd0);
    mem_done = 1'b1;
    tick();
    chk("t1_e2_done", 64'(cpu_done), 64'd1);
    chk("t1_e2_err", 64'(cpu_err), 64'd0);
    chk("t1_e2_rdata", 64'(cpu_rdata), 64'h1234_5678_9ABC);
    chk("t1_e2_strobe", 64'(mem_read), 64'd0);
    mem_done = 1'b0; cpu_read = 1'b0;
    tick();
    chk("t1_e3_done", 64'(cpu_done), 64'd0);
    tick();

    // Write to dev0 (PIC window)
    cpu_addr = 15'o77770; cpu_write = 1'b1; cpu_wdata = 48'hFFFF;
    dev_rdata[0 +: DW] = 48'hDEAD_BEEF;
    tick(); tick();
    chk("t2_dev_write", 64'(dev_write), 64'h01);
    chk("t2_dev_read", 64'(dev_read), 64'h00);
    chk("t2_mem_strobes", 64'({mem_read, mem_write}), 64'd0);
    chk("t2_dev_wdata", 64'(dev_wdata), 64'hFFFF);
    chk("t2_dev_addr", 64'(dev_addr), 64'(15'o77770));
    dev_done = 6'b000001;
    tick();
    chk("t2_done", 64'(cpu_done), 64'd1);
    chk("t2_err", 64'(cpu_err), 64'd0);
    chk("t2_rdata", 64'(cpu_rdata), 64'd0);
    chk("t2_strobe_off", 64'(dev_write), 64'd0);
    dev_done = '0; cpu_write = 1'b0;
    tick(); tick();

    // Read dev1 that never answers: 255 strobe cycles then error
    cpu_addr = 15'o77760; cpu_read = 1'b1;
    dev_rdata[DW +: DW] = 48'h5555_AAAA;
    tick(); tick();
    chk("t3_dev_read", 64'(dev_read), 64'h02);
    cnt = 1;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (dev_read[1]) cnt++;
      else break;
    end
    chk("t3_strobe_cycles", 64'(cnt), 64'd255);
    chk("t3_done", 64'(cpu_done), 64'd1);
    chk("t3_err", 64'(cpu_err), 64'd1);
    chk("t3_rdata", 64'(cpu_rdata), 64'd0);
    cpu_read = 1'b0; dev_done = 6'b000010;
    tick();
    chk("t3_late_done_a", 64'(cpu_done), 64'd0);
    tick();
    chk("t3_late_done_b", 64'(cpu_done), 64'd0);
    dev_done = '0;
    tick();
    chk("t3_late_done_c", 64'({cpu_done, dev_read}), 64'd0);

    // Unmapped I/O window
    cpu_addr = 15'o77000; cpu_read = 1'b1;
    tick(); tick();
    chk("t4_e1_strobes", 64'({mem_read, mem_write, dev_read, dev_write}), 64'd0);
    chk("t4_e1_done", 64'(cpu_done), 64'd0);
    tick();
    chk("t4_done", 64'(cpu_done), 64'd1);
    chk("t4_err", 64'(cpu_err), 64'd1);
    chk("t4_e2_strobes", 64'({mem_read, mem_write, dev_read, dev_write}), 64'd0);
`ifdef MESM6_BUSCTL_ERRLOG_EN
    chk("t4_err_valid", 64'(err_valid), 64'd1);
    chk("t4_err_addr", 64'(err_addr), 64'(15'o77000));
`endif
    cpu_read = 1'b0;
    tick(); tick();

    // cpu_read held 5 cycles after cpu_done: one access only
    cpu_addr = 15'o00100; cpu_read = 1'b1; mem_done = 1'b1; mem_rdata = 48'hABC;
    ndone = 0; nstb = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (cpu_done) ndone++;
      if (mem_read) nstb++;
    end
    chk("t5_done_count", 64'(ndone), 64'd1);
    chk("t5_strobe_count", 64'(nstb), 64'd1);
    cpu_read = 1'b0; mem_done = 1'b0;
    tick(); tick();

    // Read and write together: error, no strobe
    cpu_addr = 15'o00200; cpu_read = 1'b1; cpu_write = 1'b1;
    tick(); tick();
    chk("t5rw_e1_strobes", 64'({mem_read, mem_write, dev_read, dev_write}), 64'd0);
    tick();
    chk("t5rw_done_err", 64'({cpu_done, cpu_err}), 64'b11);
    chk("t5rw_e2_strobes", 64'({mem_read, mem_write}), 64'd0);
`ifdef MESM6_BUSCTL_ERRLOG_EN
    chk("t5rw_err_addr_kept", 64'(err_addr), 64'(15'o77000));
`endif
    cpu_read = 1'b0; cpu_write = 1'b0;
    tick(); tick();
`ifdef MESM6_BUSCTL_ERRLOG_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errlog_cleared", 64'(err_valid), 64'd0);
`endif

    // Asynchronous reset during ACCESS
    cpu_addr = 15'o00300; cpu_read = 1'b1;
    tick(); tick();
    chk("t6_strobe_before", 64'(mem_read), 64'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_strobe_async", 64'(mem_read), 64'd0);
    chk("t6_done_async", 64'(cpu_done), 64'd0);
    cpu_read = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    cpu_addr = 15'o00400; cpu_read = 1'b1; mem_done = 1'b1; mem_rdata = 48'h77;
    tick();
    chk("t6_post_e0", 64'(mem_read), 64'd0);
    tick();
    chk("t6_post_e1", 64'(mem_read), 64'd1);
    tick();
    chk("t6_post_done", 64'(cpu_done), 64'd1);
    chk("t6_post_rdata", 64'(cpu_rdata), 64'h77);
    cpu_read = 1'b0; mem_done = 1'b0;
    tick(); tick();

    // Interrupt vector
    dev_int = 6'b000110; #1;
    chk("irq_a", 64'(pic_irq), 64'h3);
    dev_int = 6'b000001; #1;
    chk("irq_pic_self", 64'(pic_irq), 64'h0);
    dev_int = 6'b100001; #1;
    chk("irq_top", 64'(pic_irq), 64'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
